// File: rtl/ram_io_responder_pkg.sv
// Shared constants, state encoding and address-decode helper for the RAM/IO responder.
package ram_io_responder_pkg;

  localparam logic [31:0] IO_CONSOLE_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR    = 32'h0003_0004;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } run_state_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/ram_io_responder_tx_byte_fifo.sv
// tx_byte_fifo: synchronous byte FIFO with wrap-bit pointers; all state freezes while rdy is low.
module tx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = rdy && pop && !empty;
  assign do_push = rdy && push && (!full || do_pop);

  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};

  assign dout = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-serial RAM responder with memory-mapped console FIFO and drained halt.
// Optional feature: define IO_READ_EN to let reads of the console address pop RX bytes.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_ram_rw,
  input  logic [31:0] in_ram_address,
  input  logic [7:0]  in_ram_data,
  output logic [7:0]  out_ram_data,
  output logic        out_tx_valid,
  output logic [7:0]  out_tx_data,
  input  logic        in_tx_ready,
  output logic        out_tx_overflow,
  output logic        out_halt,
  input  logic        in_rx_valid,
  input  logic [7:0]  in_rx_data,
  output logic        out_rx_ack
);

  logic [7:0]            mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  io_hit, ram_wr, console_wr, halt_wr;
  logic                  tx_pop, fifo_full, fifo_empty, drop;
  logic                  rx_pop;
  logic [7:0]            io_rd_data;
  logic [7:0]            rd_data_q;
  logic                  overflow_q, halt_q, rx_ack_q;
  run_state_e            state_q;

  assign io_hit     = is_io(in_ram_address);
  assign ram_idx    = in_ram_address[ADDR_WIDTH-1:0];
  assign ram_wr     = rdy && !in_ram_rw && !io_hit;
  assign console_wr = !in_ram_rw && (in_ram_address == IO_CONSOLE_ADDR);
  assign halt_wr    = !in_ram_rw && (in_ram_address == IO_HALT_ADDR);
  assign tx_pop     = out_tx_valid && in_tx_ready;
  assign drop       = console_wr && fifo_full && !tx_pop;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .push  (console_wr),
    .pop   (tx_pop),
    .din   (in_ram_data),
    .dout  (out_tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_tx_valid = !fifo_empty;

`ifdef IO_READ_EN
  assign rx_pop = in_ram_rw && (in_ram_address == IO_CONSOLE_ADDR) && in_rx_valid;
`else
  assign rx_pop = 1'b0;
  wire unused_rx = ^{in_rx_valid, in_rx_data};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    io_rd_data = '0;
    if (in_ram_address == IO_HALT_ADDR) begin
      io_rd_data = {7'b0, fifo_full};
    end
`ifdef IO_READ_EN
    else if (rx_pop) begin
      io_rd_data = in_rx_data;
    end
`endif
  end

  // NOTE: the RAM array has no reset; clearing it would force a per-entry reset network.
  always_ff @(posedge clk) begin
    if (ram_wr) mem_q[ram_idx] <= in_ram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      rx_ack_q   <= 1'b0;
      state_q    <= ST_RUN;
    end else if (rdy) begin
      if (in_ram_rw) rd_data_q <= io_hit ? io_rd_data : mem_q[ram_idx];
      rx_ack_q <= rx_pop;
      if (drop) overflow_q <= 1'b1;
      unique case (state_q)
        ST_RUN: if (halt_wr) state_q <= ST_DRAIN;
        // A console byte arriving this cycle keeps us draining so it is not stranded.
        ST_DRAIN: begin
          if (fifo_empty && !console_wr) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  assign out_ram_data    = rd_data_q;
  assign out_tx_overflow = overflow_q;
  assign out_halt        = halt_q;
  assign out_rx_ack      = rx_ack_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder (default build and IO_READ_EN build).
module tb_ram_io_responder;

  localparam logic [31:0] CONS = 32'h0003_0000;
  localparam logic [31:0] HALT = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst, rdy, in_ram_rw, in_tx_ready, in_rx_valid;
  logic [31:0] in_ram_address;
  logic [7:0]  in_ram_data, in_rx_data;
  logic [7:0]  out_ram_data, out_tx_data;
  logic        out_tx_valid, out_tx_overflow, out_halt, out_rx_ack;

  int n_cmp = 0;
  int n_bad = 0;

  ram_io_responder dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_ram_rw       (in_ram_rw),
    .in_ram_address  (in_ram_address),
    .in_ram_data     (in_ram_data),
    .out_ram_data    (out_ram_data),
    .out_tx_valid    (out_tx_valid),
    .out_tx_data     (out_tx_data),
    .in_tx_ready     (in_tx_ready),
    .out_tx_overflow (out_tx_overflow),
    .out_halt        (out_halt),
    .in_rx_valid     (in_rx_valid),
    .in_rx_data      (in_rx_data),
    .out_rx_ack      (out_rx_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_ram_rw      = 1'b1;
    in_ram_address = '0;
    in_ram_data    = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    in_ram_rw      = 1'b0;
    in_ram_address = a;
    in_ram_data    = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    in_ram_rw      = 1'b1;
    in_ram_address = a;
    tick();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; in_tx_ready = 1'b0;
    in_rx_valid = 1'b0; in_rx_data = '0;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ram_data", out_ram_data, 0);
    check("rst_tx_valid", out_tx_valid, 0);
    check("rst_tx_data", out_tx_data, 0);
    check("rst_overflow", out_tx_overflow, 0);
    check("rst_halt", out_halt, 0);
    check("rst_rx_ack", out_rx_ack, 0);

    // RAM write/read, hold on write, top index, upper-bit aliasing
    wr(32'h10, 8'hAB);
    rd(32'h10);
    check("rd_after_wr", out_ram_data, 8'hAB);
    wr(32'h11, 8'h99);
    check("wr_holds_rdata", out_ram_data, 8'hAB);
    rd(32'h11);
    check("rd_0x11", out_ram_data, 8'h99);
    wr(32'h1FFFF, 8'h5C);
    rd(32'h1FFFF);
    check("rd_top_index", out_ram_data, 8'h5C);
    wr(32'h20010, 8'h77);
    rd(32'h10);
    check("alias_upper_bits", out_ram_data, 8'h77);

    // Console 'H','i' then drain
    wr(CONS, 8'h48);
    wr(CONS, 8'h69);
    check("hi_valid", out_tx_valid, 1);
    check("hi_head_H", out_tx_data, 8'h48);
    in_tx_ready = 1'b1;
    tick();
    check("hi_head_i", out_tx_data, 8'h69);
    tick();
    check("hi_empty", out_tx_valid, 0);
    in_tx_ready = 1'b0;

    // Full FIFO with simultaneous pop accepts the push
    for (int i = 0; i < 8; i++) wr(CONS, 8'(8'h20 + i));
    rd(HALT);
    check("full_status", out_ram_data, 8'h01);
    in_tx_ready = 1'b1;
    wr(CONS, 8'h28);
    in_tx_ready = 1'b0;
    check("full_pop_no_ovf", out_tx_overflow, 0);
    rd(HALT);
    check("full_pop_still_full", out_ram_data, 8'h01);
    in_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("full_pop_drain", out_tx_data, 32'(8'h21 + i));
      tick();
    end
    check("full_pop_empty", out_tx_valid, 0);
    in_tx_ready = 1'b0;

    // Overflow: DEPTH+1 writes with the sink stalled
    for (int i = 0; i < 8; i++) wr(CONS, 8'(8'h10 + i));
    check("ovf_not_yet", out_tx_overflow, 0);
    wr(CONS, 8'h18);
    check("ovf_set", out_tx_overflow, 1);
    rd(HALT);
    check("ovf_full_status", out_ram_data, 8'h01);
    in_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", out_tx_data, 32'(8'h10 + i));
      tick();
    end
    check("ovf_empty", out_tx_valid, 0);
    in_tx_ready = 1'b0;
    rd(HALT);
    check("not_full_status", out_ram_data, 8'h00);
    check("ovf_sticky", out_tx_overflow, 1);

    // Halt drains the FIFO first
    wr(CONS, 8'h41);
    wr(HALT, 8'h00);
    repeat (3) tick();
    check("drain_halt_low", out_halt, 0);
    check("drain_valid", out_tx_valid, 1);
    in_tx_ready = 1'b1;
    tick();
    check("drain_popped_halt_low", out_halt, 0);
    check("drain_popped_empty", out_tx_valid, 0);
    tick();
    check("halt_set", out_halt, 1);
    in_tx_ready = 1'b0;
    wr(HALT, 8'h00);
    repeat (2) tick();
    check("halt_sticky", out_halt, 1);
    wr(32'h30, 8'h5A);
    rd(32'h30);
    check("halted_ram_rd", out_ram_data, 8'h5A);

    // Reset in HALTED flushes and clears
    wr(CONS, 8'h55);
    check("halted_push", out_tx_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_halted_halt", out_halt, 0);
    check("rst_halted_valid", out_tx_valid, 0);
    check("rst_halted_ovf", out_tx_overflow, 0);

    // rdy = 0 freezes RAM, read register and FIFO
    wr(32'h20, 8'h11);
    rdy = 1'b0;
    wr(32'h20, 8'h22);
    rdy = 1'b1;
    rd(32'h20);
    check("rdy_low_no_wr", out_ram_data, 8'h11);
    rdy = 1'b0;
    rd(32'h10);
    check("rdy_low_rd_hold", out_ram_data, 8'h11);
    rdy = 1'b1;
    wr(CONS, 8'h66);
    rdy = 1'b0;
    in_tx_ready = 1'b1;
    tick();
    check("rdy_low_no_pop", out_tx_valid, 1);
    check("rdy_low_head", out_tx_data, 8'h66);
    rdy = 1'b1;
    tick();
    check("rdy_high_pop", out_tx_valid, 0);
    in_tx_ready = 1'b0;

    // IO reads
    rd(32'h30008);
    check("io_other_rd", out_ram_data, 0);
`ifdef IO_READ_EN
    in_rx_valid = 1'b1;
    in_rx_data  = 8'h37;
    rd(CONS);
    in_rx_valid = 1'b0;
    check("rx_data", out_ram_data, 8'h37);
    check("rx_ack_pulse", out_rx_ack, 1);
    tick();
    check("rx_ack_end", out_rx_ack, 0);
    rd(CONS);
    check("rx_empty_data", out_ram_data, 0);
    check("rx_empty_ack", out_rx_ack, 0);
`else
    in_rx_valid = 1'b1;
    in_rx_data  = 8'h37;
    rd(CONS);
    in_rx_valid = 1'b0;
    check("cons_rd_zero", out_ram_data, 0);
    check("rx_ack_tied", out_rx_ack, 0);
`endif

    // Idle pattern has no side effects
    repeat (5) tick();
    check("idle_valid", out_tx_valid, 0);
    check("idle_halt", out_halt, 0);
    check("idle_ovf", out_tx_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
